// File: rtl/xgmii_pkg.sv
// Shared XGMII receive constants, status error bit positions and FSM encoding
// for the rx frame checker.
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_PRE   = 8'h55;
    localparam logic [7:0] XGMII_SFD   = 8'hD5;

    localparam int ERR_CTRL     = 0;
    localparam int ERR_PRE      = 1;
    localparam int ERR_RUNT     = 2;
    localparam int ERR_OVERSIZE = 3;
    localparam int ERR_ABORT    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA
    } rx_state_e;

    function automatic logic [4:0] err_bit(input int idx);
        return 5'(1) << idx;
    endfunction

    // Length accumulator saturates rather than wrapping so jabber stays oversize.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/xgmii_rx_lane_decode.sv
// Per-word control-character decode: start positions, first control lane
// (terminate position) and illegal control characters.
module xgmii_rx_lane_decode
    import xgmii_pkg::*;
(
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic        start_lane0,
    output logic        start_lane4,
    output logic        term_valid,
    output logic [2:0]  term_lane,
    output logic        ctrl_err
);

    logic [7:0] t_byte;

    assign start_lane0 = xgmii_rxc[0] && (xgmii_rxd[7:0] == XGMII_START);
    assign start_lane4 = xgmii_rxc[4] && (xgmii_rxd[39:32] == XGMII_START);

    // term_lane is the lowest control lane; it is a terminate only if term_valid.
    always_comb begin
        term_lane = 3'd0;
        for (int k = 7; k >= 0; k--)
            if (xgmii_rxc[k]) term_lane = 3'(k);
    end

    assign t_byte     = xgmii_rxd[{term_lane, 3'b000} +: 8];
    assign term_valid = (|xgmii_rxc) && (t_byte == XGMII_TERM);

    always_comb begin
        ctrl_err = (|xgmii_rxc) && (t_byte != XGMII_TERM);
        for (int k = 0; k < 8; k++)
            if (xgmii_rxc[k] && (3'(k) > term_lane) &&
                (xgmii_rxd[8*k +: 8] != XGMII_IDLE) && (xgmii_rxd[8*k +: 8] != XGMII_START))
                ctrl_err = 1'b1;
    end

endmodule

// File: rtl/xgmii_rx_frame_checker.sv
// Passive XGMII rx monitor: frame delineation, preamble/control checks,
// post-SFD length measurement, per-frame status pulse and good/bad counters.
module xgmii_rx_frame_checker
    import xgmii_pkg::*;
#(
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1518,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            xgmii_rxd,
    input  logic [7:0]             xgmii_rxc,
    input  logic                   rx_block_lock,
    input  logic                   cnt_clear,
    output logic                   status_valid,
    output logic [15:0]            status_len,
    output logic                   status_good,
    output logic [4:0]             status_err,
    output logic [COUNT_WIDTH-1:0] frame_good_count,
    output logic [COUNT_WIDTH-1:0] frame_bad_count,
    output logic                   in_frame
);

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    logic       start_lane0, start_lane4, term_valid, ctrl_err;
    logic [2:0] term_lane;

    xgmii_rx_lane_decode u_dec (
        .xgmii_rxd   (xgmii_rxd),
        .xgmii_rxc   (xgmii_rxc),
        .start_lane0 (start_lane0),
        .start_lane4 (start_lane4),
        .term_valid  (term_valid),
        .term_lane   (term_lane),
        .ctrl_err    (ctrl_err)
    );

    logic pre0_ok, pre4_ok, preword_ok;
    assign pre0_ok    = (xgmii_rxc[7:1] == 7'd0) && (xgmii_rxd[55:8] == {6{XGMII_PRE}}) &&
                        (xgmii_rxd[63:56] == XGMII_SFD);
    assign pre4_ok    = (xgmii_rxc[7:5] == 3'd0) && (xgmii_rxd[63:40] == {3{XGMII_PRE}});
    assign preword_ok = (xgmii_rxc[3:0] == 4'd0) && (xgmii_rxd[23:0] == {3{XGMII_PRE}}) &&
                        (xgmii_rxd[31:24] == XGMII_SFD);

    logic [4:0] ctrl_e, pre0_e, pre4_e, preword_e;
    assign ctrl_e    = ctrl_err   ? err_bit(ERR_CTRL) : 5'd0;
    assign pre0_e    = pre0_ok    ? 5'd0 : err_bit(ERR_PRE);
    assign pre4_e    = pre4_ok    ? 5'd0 : err_bit(ERR_PRE);
    assign preword_e = preword_ok ? 5'd0 : err_bit(ERR_PRE);

    rx_state_e   state, nx_state;
    logic [15:0] len, nx_len, close_len;
    logic [4:0]  ferr, nx_err, close_err, fin_err;
    logic        close, abort;

    always_comb begin
        nx_state  = state;
        nx_len    = len;
        nx_err    = ferr;
        close     = 1'b0;
        abort     = 1'b0;
        close_len = len;
        close_err = ferr;
        case (state)
            ST_IDLE: begin
                if (rx_block_lock && start_lane0) begin
                    nx_state = ST_DATA;
                    nx_len   = 16'd0;
                    nx_err   = pre0_e;
                end else if (rx_block_lock && start_lane4) begin
                    nx_state = ST_PRE;
                    nx_len   = 16'd0;
                    nx_err   = pre4_e;
                end
            end
            ST_PRE: begin
                if (!rx_block_lock) begin
                    close    = 1'b1;
                    abort    = 1'b1;
                    nx_state = ST_IDLE;
                end else if (term_valid && term_lane[2]) begin
                    close     = 1'b1;
                    close_len = 16'(term_lane[1:0]);
                    close_err = ferr | preword_e | ctrl_e;
                    nx_state  = ST_IDLE;
                end else begin
                    nx_state = ST_DATA;
                    nx_len   = 16'd4;
                    nx_err   = ferr | preword_e | ctrl_e;
                end
            end
            ST_DATA: begin
                if (!rx_block_lock) begin
                    close    = 1'b1;
                    abort    = 1'b1;
                    nx_state = ST_IDLE;
                end else if (term_valid || start_lane0 || (start_lane4 && term_lane == 3'd4)) begin
                    // A START without a preceding TERM closes the frame; decode flags it as ctrl.
                    close     = 1'b1;
                    close_len = sat_add(len, {1'b0, term_lane});
                    close_err = ferr | ctrl_e;
                    nx_state  = ST_IDLE;
                    if (start_lane0) begin
                        nx_state = ST_DATA;
                        nx_len   = 16'd0;
                        nx_err   = pre0_e;
                    end else if (start_lane4) begin
                        nx_state = ST_PRE;
                        nx_len   = 16'd0;
                        nx_err   = pre4_e;
                    end
                end else begin
                    nx_len = sat_add(len, 4'd8);
                    nx_err = ferr | ctrl_e;
                end
            end
            default: nx_state = ST_IDLE;
        endcase
    end

    // Size checks only apply to frames that ended on the wire, not to aborts.
    always_comb begin
        fin_err = close_err;
        if (abort) begin
            fin_err = fin_err | err_bit(ERR_ABORT);
        end else begin
            if (close_len < MIN_L) fin_err = fin_err | err_bit(ERR_RUNT);
            if (close_len > MAX_L) fin_err = fin_err | err_bit(ERR_OVERSIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            len              <= '0;
            ferr             <= '0;
            status_valid     <= 1'b0;
            status_len       <= '0;
            status_err       <= '0;
            status_good      <= 1'b0;
            frame_good_count <= '0;
            frame_bad_count  <= '0;
        end else begin
            state        <= nx_state;
            len          <= nx_len;
            ferr         <= nx_err;
            status_valid <= close;
            if (close) begin
                status_len  <= close_len;
                status_err  <= fin_err;
                status_good <= ~|fin_err;
            end
            if (cnt_clear) begin
                frame_good_count <= '0;
                frame_bad_count  <= '0;
            end else if (close) begin
                if (~|fin_err) frame_good_count <= frame_good_count + COUNT_WIDTH'(1);
                else           frame_bad_count  <= frame_bad_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign in_frame = (state != ST_IDLE);

endmodule
